// File: rtl/i2c_seq_pkg.sv
// Shared constants, bus payload type and step tables for the I2C register-access sequencer.
package i2c_seq_pkg;

    localparam int unsigned ADR_W = 3;
    localparam int unsigned DAT_W = 8;

    localparam logic [ADR_W-1:0] ADR_PRER_LO = 3'd0;
    localparam logic [ADR_W-1:0] ADR_PRER_HI = 3'd1;
    localparam logic [ADR_W-1:0] ADR_CTR     = 3'd2;
    localparam logic [ADR_W-1:0] ADR_TXR     = 3'd3;
    localparam logic [ADR_W-1:0] ADR_RXR     = 3'd3;
    localparam logic [ADR_W-1:0] ADR_CR      = 3'd4;
    localparam logic [ADR_W-1:0] ADR_SR      = 3'd4;

    localparam logic [DAT_W-1:0] CR_STA_WR      = 8'h90;
    localparam logic [DAT_W-1:0] CR_WR          = 8'h10;
    localparam logic [DAT_W-1:0] CR_WR_STO      = 8'h50;
    localparam logic [DAT_W-1:0] CR_RD_NACK_STO = 8'h68;
    localparam logic [DAT_W-1:0] CR_STO         = 8'h40;
    localparam logic [DAT_W-1:0] CTR_EN         = 8'h80;

    localparam int unsigned SR_TIP   = 1;
    localparam int unsigned SR_AL    = 5;
    localparam int unsigned SR_RXACK = 7;

    typedef enum logic [3:0] {
        ST_RESET, ST_INIT_LO, ST_INIT_HI, ST_INIT_CTR, ST_IDLE,
        ST_TX_WR, ST_CR_WR, ST_POLL, ST_CHECK,
        ST_STOP_WR, ST_STOP_POLL, ST_RX_RD, ST_RESP
    } seq_state_e;

    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

    // CR command for each byte step; steps 2/3 differ between write and read
    function automatic logic [DAT_W-1:0] step_cr(input logic rw, input logic [1:0] step);
        logic [DAT_W-1:0] cr;
        case (step)
            2'd0:    cr = CR_STA_WR;
            2'd1:    cr = CR_WR;
            2'd2:    cr = rw ? CR_STA_WR : CR_WR_STO;
            default: cr = CR_RD_NACK_STO;
        endcase
        return cr;
    endfunction

    function automatic logic [DAT_W-1:0] step_txr(input logic rw, input logic [1:0] step,
                                                  input logic [6:0] dev, input logic [7:0] rad,
                                                  input logic [7:0] wdata);
        logic [DAT_W-1:0] tx;
        case (step)
            2'd0:    tx = {dev, 1'b0};
            2'd1:    tx = rad;
            2'd2:    tx = rw ? {dev, 1'b1} : wdata;
            default: tx = 8'h00;
        endcase
        return tx;
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// One-transfer Wishbone master: a req pulse launches a single access held until ack.
module wb_single_master
    import i2c_seq_pkg::*;
(
    input  logic             wb_clk_i,
    input  logic             arst_i,
    input  logic             req,
    input  wb_req_t          req_pl,
    output logic             done_c,
    output logic [DAT_W-1:0] rdata_c,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    output logic             wbm_we_o,
    output logic             wbm_stb_o,
    output logic             wbm_cyc_o,
    input  logic [DAT_W-1:0] wbm_dat_i,
    input  logic             wbm_ack_i
);

    assign done_c  = wbm_cyc_o & wbm_ack_i;
    assign rdata_c = wbm_dat_i;

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else if (done_c) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else if (req && !wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= req_pl.we;
            wbm_adr_o <= req_pl.adr;
            wbm_dat_o <= req_pl.dat;
        end
    end

endmodule

// File: rtl/i2c_reg_access_seq.sv
// Wishbone sequencer for single-byte I2C register writes and random reads via i2c_master_top.
// Optional SR-poll watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_reg_access_seq
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE      = 16'h003F,
    parameter logic [15:0] TIMEOUT_POLLS = 16'd4096
) (
    input  logic             wb_clk_i,
    input  logic             arst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rw,
    input  logic [6:0]       cmd_dev,
    input  logic [7:0]       cmd_reg,
    input  logic [7:0]       cmd_wdata,
    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic             rsp_nack,
    output logic             rsp_al,
    output logic             rsp_timeout,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    output logic             wbm_we_o,
    output logic             wbm_stb_o,
    output logic             wbm_cyc_o,
    input  logic [DAT_W-1:0] wbm_dat_i,
    input  logic             wbm_ack_i
);

    seq_state_e       state_q;
    logic             rw_q;
    logic [6:0]       dev_q;
    logic [7:0]       rad_q;
    logic [7:0]       wdata_q;
    logic [1:0]       step_q;
    logic             al_q;
    logic             rxack_q;
    logic             req_q;
    wb_req_t          req_pl_q;
    logic             done_c;
    logic [DAT_W-1:0] rdata_c;
    logic [1:0]       nxt_step_c;
    logic             last_c;
    logic             rd_final_c;

    assign nxt_step_c = step_q + 2'd1;
    assign last_c     = (step_q == (rw_q ? 2'd3 : 2'd2));
    assign rd_final_c = rw_q && (step_q == 2'd3);

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt_q;
    logic [15:0] poll_inc_c;
    logic        pend_to_q;
    // saturating poll count, never wraps
    assign poll_inc_c = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
`else
    logic unused_timeout_polls;
    assign unused_timeout_polls = ^TIMEOUT_POLLS;
    assign rsp_timeout          = 1'b0;
`endif

    wb_single_master u_wbm (
        .wb_clk_i  (wb_clk_i),
        .arst_i    (arst_i),
        .req       (req_q),
        .req_pl    (req_pl_q),
        .done_c    (done_c),
        .rdata_c   (rdata_c),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q   <= ST_RESET;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
            rsp_al    <= 1'b0;
            rw_q      <= 1'b0;
            dev_q     <= '0;
            rad_q     <= '0;
            wdata_q   <= '0;
            step_q    <= '0;
            al_q      <= 1'b0;
            rxack_q   <= 1'b0;
            req_q     <= 1'b0;
            req_pl_q  <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            poll_cnt_q  <= '0;
            pend_to_q   <= 1'b0;
`endif
        end else begin
            req_q <= 1'b0;
            case (state_q)
                ST_RESET: begin
                    req_q    <= 1'b1;
                    req_pl_q <= wb_req_t'{we: 1'b1, adr: ADR_PRER_LO, dat: PRESCALE[7:0]};
                    state_q  <= ST_INIT_LO;
                end
                ST_INIT_LO: if (done_c) begin
                    req_q    <= 1'b1;
                    req_pl_q <= wb_req_t'{we: 1'b1, adr: ADR_PRER_HI, dat: PRESCALE[15:8]};
                    state_q  <= ST_INIT_HI;
                end
                ST_INIT_HI: if (done_c) begin
                    req_q    <= 1'b1;
                    req_pl_q <= wb_req_t'{we: 1'b1, adr: ADR_CTR, dat: CTR_EN};
                    state_q  <= ST_INIT_CTR;
                end
                ST_INIT_CTR: if (done_c) begin
                    cmd_ready <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                ST_IDLE: if (cmd_valid && cmd_ready) begin
                    cmd_ready <= 1'b0;
                    rw_q      <= cmd_rw;
                    dev_q     <= cmd_dev;
                    rad_q     <= cmd_reg;
                    wdata_q   <= cmd_wdata;
                    step_q    <= 2'd0;
`ifdef I2C_SEQ_TIMEOUT_EN
                    pend_to_q <= 1'b0;
`endif
                    req_q     <= 1'b1;
                    req_pl_q  <= wb_req_t'{we: 1'b1, adr: ADR_TXR, dat: {cmd_dev, 1'b0}};
                    state_q   <= ST_TX_WR;
                end
                ST_TX_WR: if (done_c) begin
                    req_q    <= 1'b1;
                    req_pl_q <= wb_req_t'{we: 1'b1, adr: ADR_CR, dat: step_cr(rw_q, step_q)};
                    state_q  <= ST_CR_WR;
                end
                ST_CR_WR: if (done_c) begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    poll_cnt_q <= '0;
`endif
                    req_q    <= 1'b1;
                    req_pl_q <= wb_req_t'{we: 1'b0, adr: ADR_SR, dat: 8'h00};
                    state_q  <= ST_POLL;
                end
                ST_POLL: if (done_c) begin
                    if (rdata_c[SR_TIP]) begin
`ifdef I2C_SEQ_TIMEOUT_EN
                        if (poll_inc_c >= TIMEOUT_POLLS) begin
                            pend_to_q <= 1'b1;
                            req_q     <= 1'b1;
                            req_pl_q  <= wb_req_t'{we: 1'b1, adr: ADR_CR, dat: CR_STO};
                            state_q   <= ST_STOP_WR;
                        end else begin
                            poll_cnt_q <= poll_inc_c;
                            req_q      <= 1'b1;
                            req_pl_q   <= wb_req_t'{we: 1'b0, adr: ADR_SR, dat: 8'h00};
                        end
`else
                        req_q    <= 1'b1;
                        req_pl_q <= wb_req_t'{we: 1'b0, adr: ADR_SR, dat: 8'h00};
`endif
                    end else begin
                        al_q    <= rdata_c[SR_AL];
                        rxack_q <= rdata_c[SR_RXACK];
                        state_q <= ST_CHECK;
                    end
                end
                // arbitration loss outranks NACK; RxACK on the final read byte is our own NACK
                ST_CHECK: begin
                    if (al_q) begin
                        rsp_valid <= 1'b1;
                        rsp_al    <= 1'b1;
                        state_q   <= ST_RESP;
                    end else if (rxack_q && !rd_final_c) begin
                        req_q    <= 1'b1;
                        req_pl_q <= wb_req_t'{we: 1'b1, adr: ADR_CR, dat: CR_STO};
                        state_q  <= ST_STOP_WR;
                    end else if (last_c) begin
                        if (rw_q) begin
                            req_q    <= 1'b1;
                            req_pl_q <= wb_req_t'{we: 1'b0, adr: ADR_RXR, dat: 8'h00};
                            state_q  <= ST_RX_RD;
                        end else begin
                            rsp_valid <= 1'b1;
                            state_q   <= ST_RESP;
                        end
                    end else begin
                        step_q <= nxt_step_c;
                        req_q  <= 1'b1;
                        if (nxt_step_c != 2'd3) begin
                            req_pl_q <= wb_req_t'{we: 1'b1, adr: ADR_TXR,
                                dat: step_txr(rw_q, nxt_step_c, dev_q, rad_q, wdata_q)};
                            state_q  <= ST_TX_WR;
                        end else begin
                            req_pl_q <= wb_req_t'{we: 1'b1, adr: ADR_CR, dat: step_cr(rw_q, nxt_step_c)};
                            state_q  <= ST_CR_WR;
                        end
                    end
                end
                ST_STOP_WR: if (done_c) begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    if (pend_to_q) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        req_q    <= 1'b1;
                        req_pl_q <= wb_req_t'{we: 1'b0, adr: ADR_SR, dat: 8'h00};
                        state_q  <= ST_STOP_POLL;
                    end
`else
                    req_q    <= 1'b1;
                    req_pl_q <= wb_req_t'{we: 1'b0, adr: ADR_SR, dat: 8'h00};
                    state_q  <= ST_STOP_POLL;
`endif
                end
                ST_STOP_POLL: if (done_c) begin
                    if (rdata_c[SR_TIP]) begin
                        req_q    <= 1'b1;
                        req_pl_q <= wb_req_t'{we: 1'b0, adr: ADR_SR, dat: 8'h00};
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_nack  <= 1'b1;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RX_RD: if (done_c) begin
                    rsp_rdata <= rdata_c;
                    rsp_valid <= 1'b1;
                    state_q   <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_nack  <= 1'b0;
                    rsp_al    <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
                    rsp_timeout <= 1'b0;
`endif
                    cmd_ready <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_access_seq.sv
// Bench for i2c_reg_access_seq: behavioural i2c_master_top/slave responder plus a transaction-list reference.
module tb_i2c_reg_access_seq;

    localparam logic [6:0] SLV = 7'h10;

    logic       wb_clk_i = 1'b0;
    logic       arst_i;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg, cmd_wdata;
    logic       rsp_valid, rsp_nack, rsp_al, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o, wbm_dat_i;
    logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;

    always #5 wb_clk_i = ~wb_clk_i;

    i2c_reg_access_seq #(.PRESCALE(16'h003F), .TIMEOUT_POLLS(16'd8)) dut (
        .wb_clk_i(wb_clk_i), .arst_i(arst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_al(rsp_al), .rsp_timeout(rsp_timeout),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o),
        .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- i2c core + slave behaviour seen through the register file
    logic [7:0]  smem [256];
    logic [7:0]  txr_m = 8'h00, rxr_m = 8'h00, ptr_m = 8'h00;
    bit          al_m, rxack_m, force_tip, seen_cr10;
    int          tip_left, byte_idx, cr_idx, inject_al_step, sr_reads, last_sr_reads;
    int          ack_wait, cyc_cnt = 0, ctr_ack_cyc = 0;
    logic [10:0] wlog [$];
    logic [10:0] elog [$];

    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 8'h00;
    end

    always @(posedge wb_clk_i) cyc_cnt++;

    task automatic reset_model();
        tip_left = 0; al_m = 0; rxack_m = 0; ack_wait = 0; byte_idx = 0;
        sr_reads = 0;
    endtask

    task automatic cr_write(input logic [7:0] c);
        int k;
        k = cr_idx;
        cr_idx++;
        last_sr_reads = sr_reads;
        sr_reads = 0;
        tip_left = force_tip ? 1000000 : int'($urandom_range(0, 3));
        if (c == 8'h10) seen_cr10 = 1;
        if (k == inject_al_step) begin
            al_m = 1;
        end else begin
            al_m = 0;
            if (c == 8'h40) begin
                byte_idx = 0;
            end else if (c[7]) begin
                rxack_m  = (txr_m[7:1] != SLV);
                byte_idx = 0;
            end else if (c[4]) begin
                if (byte_idx == 0) ptr_m = txr_m;
                else smem[ptr_m] = txr_m;
                byte_idx++;
                rxack_m = 0;
            end else if (c[5]) begin
                rxr_m   = smem[ptr_m];
                rxack_m = 1;
            end
        end
    endtask

    task automatic sr_read(output logic [7:0] v);
        bit tip;
        tip = (tip_left > 0);
        if (tip_left > 0) tip_left--;
        sr_reads++;
        v = {rxack_m, 1'b0, al_m, 3'b000, tip, 1'b0};
    endtask

    always @(negedge wb_clk_i) begin
        logic [7:0] v;
        if (!arst_i || wbm_ack_i) begin
            wbm_ack_i = 1'b0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (ack_wait > 0) begin
                ack_wait--;
            end else begin
                wbm_ack_i = 1'b1;
                ack_wait  = int'($urandom_range(0, 2));
                if (wbm_we_o) begin
                    wlog.push_back({wbm_adr_o, wbm_dat_o});
                    if (wbm_adr_o == 3'd2) ctr_ack_cyc = cyc_cnt;
                    if (wbm_adr_o == 3'd3) txr_m = wbm_dat_o;
                    if (wbm_adr_o == 3'd4) cr_write(wbm_dat_o);
                end else if (wbm_adr_o == 3'd4) begin
                    sr_read(v);
                    wbm_dat_i = v;
                end else begin
                    wbm_dat_i = rxr_m;
                end
            end
        end
    end

    // ---------------- reference and directed steps
    logic [7:0] ref_mem [256];

    task automatic compare_log(input string tag);
        check($sformatf("%s_len", tag), 32'(wlog.size()), 32'(elog.size()));
        for (int i = 0; i < elog.size() && i < wlog.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 32'(wlog[i]), 32'(elog[i]));
    endtask

    task automatic wait_ready(input string tag);
        bit got = 0;
        for (int i = 0; i < 500; i++) begin
            if (cmd_ready) begin got = 1; break; end
            @(negedge wb_clk_i);
        end
        check({tag, "_ready_seen"}, 32'(got), 32'd1);
    endtask

    task automatic check_init(input string tag);
        wait_ready(tag);
        check({tag, "_ready_after_ctr_ack"}, 32'(cyc_cnt - ctr_ack_cyc), 32'd1);
        elog = {11'h03F, 11'h100, 11'h280};
        compare_log(tag);
    endtask

    task automatic run_cmd(input string tag, input bit rw, input logic [6:0] dev,
                           input logic [7:0] rad, input logic [7:0] wd,
                           input int al_step, input bit spam);
        int  nsteps;
        bit  e_al, e_nack, got;
        logic [7:0] cr, e_rdata;
        nsteps = rw ? 4 : 3;
        e_al = 0; e_nack = 0;
        elog.delete();
        for (int i = 0; i < nsteps; i++) begin
            if (i == 0) elog.push_back({3'd3, dev, 1'b0});
            if (i == 1) elog.push_back({3'd3, rad});
            if (i == 2) elog.push_back({3'd3, rw ? {dev, 1'b1} : wd});
            cr = (i == 0) ? 8'h90 : (i == 1) ? 8'h10 : (i == 2) ? (rw ? 8'h90 : 8'h50) : 8'h68;
            elog.push_back({3'd4, cr});
            if (i == al_step) begin e_al = 1; break; end
            if ((i == 0 || (rw && i == 2)) && dev != SLV) begin
                elog.push_back({3'd4, 8'h40});
                e_nack = 1;
                break;
            end
        end
        if (!e_al && !e_nack && !rw) ref_mem[rad] = wd;
        e_rdata = ref_mem[rad];

        wait_ready(tag);
        wlog.delete();
        cr_idx = 0;
        inject_al_step = al_step;
        cmd_rw = rw; cmd_dev = dev; cmd_reg = rad; cmd_wdata = wd; cmd_valid = 1;
        @(negedge wb_clk_i);
        cmd_valid = 0;
        if (spam) begin
            cmd_rw = 0; cmd_dev = 7'h55; cmd_reg = 8'hEE; cmd_wdata = 8'h99; cmd_valid = 1;
            repeat (4) @(negedge wb_clk_i);
            cmd_valid = 0;
        end
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid) begin got = 1; break; end
            @(negedge wb_clk_i);
        end
        check({tag, "_rsp_seen"}, 32'(got), 32'd1);
        check({tag, "_nack"}, 32'(rsp_nack), 32'(e_nack));
        check({tag, "_al"}, 32'(rsp_al), 32'(e_al));
        check({tag, "_timeout"}, 32'(rsp_timeout), 32'd0);
        check({tag, "_ready_in_pulse"}, 32'(cmd_ready), 32'd0);
        if (rw && !e_al && !e_nack) check({tag, "_rdata"}, 32'(rsp_rdata), 32'(e_rdata));
        @(negedge wb_clk_i);
        check({tag, "_pulse_one_cycle"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        compare_log(tag);
        inject_al_step = -1;
    endtask

    initial begin
        bit  rw_r;
        int  al_r;
        bit  hit;
        arst_i = 0; cmd_valid = 0; cmd_rw = 0; cmd_dev = '0; cmd_reg = '0; cmd_wdata = '0;
        force_tip = 0; seen_cr10 = 0; inject_al_step = -1; cr_idx = 0; last_sr_reads = 0;
        reset_model();
        for (int i = 0; i < 256; i++) begin smem[i] = 8'h00; ref_mem[i] = 8'h00; end
        repeat (3) @(negedge wb_clk_i);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        wlog.delete();
        arst_i = 1;
        check_init("init");

        run_cmd("wr", 0, SLV, 8'h01, 8'h0B, -1, 0);
        run_cmd("rd", 1, SLV, 8'h01, 8'h00, -1, 0);
        run_cmd("nack_wr", 0, 7'h11, 8'h02, 8'h55, -1, 0);
        run_cmd("nack_rd", 1, 7'h11, 8'h02, 8'h00, -1, 0);
        run_cmd("busy_rd", 1, SLV, 8'h01, 8'h00, -1, 1);
        run_cmd("al_wr", 0, SLV, 8'h03, 8'hA5, 1, 0);
        run_cmd("al_rdlast", 1, SLV, 8'h01, 8'h00, 3, 0);

        for (int n = 0; n < 16; n++) begin
            rw_r = 1'($urandom_range(0, 1));
            al_r = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rw_r ? 3 : 2)) : -1;
            run_cmd($sformatf("rnd%0d", n), rw_r, ($urandom_range(0, 3) == 0) ? 7'h11 : SLV,
                    8'($urandom_range(0, 7)), 8'($urandom), al_r, 0);
        end

`ifdef I2C_SEQ_TIMEOUT_EN
        wait_ready("to");
        wlog.delete(); cr_idx = 0; force_tip = 1;
        cmd_rw = 0; cmd_dev = SLV; cmd_reg = 8'h05; cmd_wdata = 8'h77; cmd_valid = 1;
        @(negedge wb_clk_i);
        cmd_valid = 0;
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            if (rsp_valid) begin hit = 1; break; end
            @(negedge wb_clk_i);
        end
        check("to_rsp_seen", 32'(hit), 32'd1);
        check("to_flag", 32'(rsp_timeout), 32'd1);
        check("to_nack", 32'(rsp_nack), 32'd0);
        check("to_sr_reads", 32'(last_sr_reads), 32'd8);
        elog = {{3'd3, SLV, 1'b0}, 11'h490, 11'h440};
        compare_log("to");
        force_tip = 0;
        @(negedge wb_clk_i);
`endif

        // reset while polling after the register-address byte
        wait_ready("mid");
        seen_cr10 = 0; cr_idx = 0;
        cmd_rw = 0; cmd_dev = SLV; cmd_reg = 8'h06; cmd_wdata = 8'h3C; cmd_valid = 1;
        @(negedge wb_clk_i);
        cmd_valid = 0;
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            if (seen_cr10 && wbm_cyc_o && !wbm_we_o && wbm_adr_o == 3'd4) begin hit = 1; break; end
            @(negedge wb_clk_i);
        end
        check("mid_poll_reached", 32'(hit), 32'd1);
        arst_i = 0;
        #1;
        check("mid_cyc_drop", 32'(wbm_cyc_o), 32'd0);
        check("mid_stb_drop", 32'(wbm_stb_o), 32'd0);
        check("mid_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge wb_clk_i);
        reset_model();
        wlog.delete();
        @(negedge wb_clk_i);
        arst_i = 1;
        check_init("reinit");
        run_cmd("post_rst_rd", 1, SLV, 8'h01, 8'h00, -1, 0);
        run_cmd("post_rst_wr", 0, SLV, 8'h06, 8'hC3, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_access_seq.md
# i2c_reg_access_seq

Hardware Wishbone sequencer that drives the I2C master core's register interface (PRER/CTR/TXR/RXR/CR/SR) so logic can perform single-byte register writes and random reads on an I2C slave without software. It sits directly upstream of `i2c_master_top` and is the only Wishbone master on that core's bus. It accepts one command at a time and returns one response.

## Interface
Parameters:
- `PRESCALE`, default 16'h003F: prescaler value; `PRER_LO` = [7:0], `PRER_HI` = [15:8].
- `TIMEOUT_POLLS`, default 16'd4096: SR polls allowed per byte before abort. Used only with the timeout feature.

Ports:
- `wb_clk_i`  in  1  single clock.
- `arst_i`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_rw`  in  1  0 = write, 1 = read.
- `cmd_dev`  in  7  slave device address.
- `cmd_reg`  in  8  slave register address.
- `cmd_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; held until the next response.
- `rsp_nack`  out  1  slave NACKed a byte.
- `rsp_al`  out  1  arbitration lost.
- `rsp_timeout`  out  1  poll watchdog expired.
- `wbm_adr_o`  out  3, `wbm_dat_o`  out  8, `wbm_we_o`  out  1, `wbm_stb_o`  out  1, `wbm_cyc_o`  out  1: Wishbone master outputs.
- `wbm_dat_i`  in  8, `wbm_ack_i`  in  1: Wishbone master inputs.

## Operation
- **Init after reset.** Write `PRER_LO` (adr 0), then `PRER_HI` (adr 1), then `CTR` = 0x80 (adr 2). Then enter IDLE.
- **Command acceptance.** A command is accepted on `cmd_valid && cmd_ready`. All `cmd_*` fields are registered at acceptance.
- **Byte step.** Each step is:
  - write TXR (adr 3), if the step carries data;
  - write CR (adr 4);
  - repeatedly read SR (adr 4) until bit 1 (TIP) = 0;
  - then check SR bit 5 (AL) first, then SR bit 7 (RxACK).
- **Write command:**
  - TXR = {dev,0}, CR = 0x90;
  - TXR = reg, CR = 0x10;
  - TXR = wdata, CR = 0x50.
- **Read command:**
  - TXR = {dev,0}, CR = 0x90;
  - TXR = reg, CR = 0x10;
  - TXR = {dev,1}, CR = 0x90 (repeated start);
  - CR = 0x68 (read, NACK, stop);
  - read RXR (adr 3) into `rsp_rdata`.
- **NACK.** RxACK = 1 on any address or write byte:
  - write CR = 0x40 (stop) and poll TIP = 0;
  - respond with `rsp_nack` = 1;
  - issue no further TXR writes.
  - RxACK is ignored on the final read byte.
- **Arbitration lost.** AL = 1: respond immediately with `rsp_al` = 1; no stop is issued.
- **Error flags.** Error flags are mutually exclusive and reported only with `rsp_valid`.
- **State machine.** RESET → INIT_LO → INIT_HI → INIT_CTR → IDLE → {TX_WR, CR_WR, POLL, CHECK} per step → (STOP_WR, STOP_POLL on NACK) → RX_RD (read only) → RESP → IDLE.

## Timing
- **Wishbone transfer:**
  - `cyc`, `stb`, `adr`, `dat` and `we` are registered and asserted together;
  - they are held until the first cycle `wbm_ack_i` = 1;
  - all are deasserted the following cycle;
  - `wbm_dat_i` is captured on the ack cycle.
- **Spacing.** At least one idle cycle separates consecutive transfers. No bursts.
- **Reset values.** All outputs are 0, including `cmd_ready`. `cmd_ready` rises on the cycle after the CTR ack.
- **Response.** `rsp_valid` pulses exactly one cycle. `cmd_ready` rises on the cycle after the pulse.
- **Busy.** `cmd_valid` while `cmd_ready` = 0 is ignored and not queued.
- **Reset mid-operation.** An asserted `arst_i` drops `cyc`/`stb` at once and restarts from INIT. `i2c_master_top` must share the same reset.
- **Poll counter.** 16 bits. It resets at every new byte step and saturates; it never wraps.

## Configuration
- `I2C_SEQ_TIMEOUT_EN` defined:
  - the poll counter is compared against `TIMEOUT_POLLS`;
  - on reaching it, write CR = 0x40 without polling;
  - respond with `rsp_timeout` = 1.
- `I2C_SEQ_TIMEOUT_EN` undefined:
  - the counter and comparator are absent;
  - polling waits indefinitely;
  - `rsp_timeout` is tied to 0.

## Structure
- **Package `i2c_seq_pkg`:**
  - register addresses PRER_LO..SR;
  - CR command constants 0x90, 0x10, 0x50, 0x68, 0x40, 0x80;
  - SR bit indices TIP = 1, AL = 5, RXACK = 7;
  - the state enum.
- **Sub-module `wb_single_master`:** one-transfer Wishbone master with req/we/adr/wdata in and done/rdata out. The sequencer FSM issues one req per register access.

## Test plan
- **Init.** Release reset with the default `PRESCALE` → writes adr 0 = 0x3F, adr 1 = 0x00, adr 2 = 0x80 in that order; `cmd_ready` = 1 afterwards.
- **Write.** rw = 0, dev = 0x10, reg = 0x01, wdata = 0x0B against the slave model → TXR sequence 0x20, 0x01, 0x0B; CR sequence 0x90, 0x10, 0x50; `rsp_valid` with all flags 0.
- **Read.** rw = 1, dev = 0x10, reg = 0x01 after the write above → CR sequence 0x90, 0x10, 0x90 (TXR 0x21), 0x68; `rsp_rdata` = 0x0B.
- **NACK.** dev = 0x11 (absent) → after the first CR 0x90, CR = 0x40 is issued; `rsp_nack` = 1; no further TXR writes.
- **Timeout.** With `I2C_SEQ_TIMEOUT_EN`, `TIMEOUT_POLLS` = 8, and the Wishbone responder forcing TIP = 1 → exactly 8 SR reads, then CR = 0x40 and `rsp_timeout` = 1.
- **Reset mid-operation.** Assert `arst_i` during the register-byte POLL state → `cyc`/`stb` go 0 immediately; after release, the init sequence repeats and the next command completes normally.
